// File: rtl/linemem_arbiter_if.sv
// rtl/linemem_arbiter_if.sv - CPU, host and line-memory signal bundle for linemem_arbiter
//
// Purpose: groups the CPU load/store port, the host preload/debug port and the
//          line-memory port into one bundle.
// Modports:
//   slave  - the arbiter: takes i_* (requests, memory read data), drives o_*.
//   master - the environment: CPU datapath, host and memory.
// Signals:
//   CPU : i_cpu_req/we/addr/wdata, o_cpu_gnt, o_cpu_stall, o_cpu_rvld, o_cpu_rdata
//   Host: i_host_req/we/addr/wdata, i_host_lock, o_host_gnt, o_host_rvld,
//         o_host_rdata, o_host_locked
//   Mem : o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata
//   LMARB_STALL_CNT_EN adds i_stall_cnt_clr and o_cpu_stall_cnt[31:0].
interface linemem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  i_cpu_req;
  logic                  i_cpu_we;
  logic [ADDR_WIDTH-1:0] i_cpu_addr;
  logic [DATA_WIDTH-1:0] i_cpu_wdata;
  logic                  o_cpu_gnt;
  logic                  o_cpu_stall;
  logic                  o_cpu_rvld;
  logic [DATA_WIDTH-1:0] o_cpu_rdata;

  logic                  i_host_req;
  logic                  i_host_we;
  logic [ADDR_WIDTH-1:0] i_host_addr;
  logic [DATA_WIDTH-1:0] i_host_wdata;
  logic                  i_host_lock;
  logic                  o_host_gnt;
  logic                  o_host_rvld;
  logic [DATA_WIDTH-1:0] o_host_rdata;
  logic                  o_host_locked;

  logic                  o_mem_re;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

`ifdef LMARB_STALL_CNT_EN
  logic                  i_stall_cnt_clr;
  logic [31:0]           o_cpu_stall_cnt;
`endif

  modport slave (
`ifdef LMARB_STALL_CNT_EN
    input  i_stall_cnt_clr,
    output o_cpu_stall_cnt,
`endif
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_gnt, o_cpu_stall, o_cpu_rvld, o_cpu_rdata,
    input  i_host_req, i_host_we, i_host_addr, i_host_wdata, i_host_lock,
    output o_host_gnt, o_host_rvld, o_host_rdata, o_host_locked,
    output o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
`ifdef LMARB_STALL_CNT_EN
    output i_stall_cnt_clr,
    input  o_cpu_stall_cnt,
`endif
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_gnt, o_cpu_stall, o_cpu_rvld, o_cpu_rdata,
    output i_host_req, i_host_we, i_host_addr, i_host_wdata, i_host_lock,
    input  o_host_gnt, o_host_rvld, o_host_rdata, o_host_locked,
    input  o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/linemem_arbiter.sv
// rtl/linemem_arbiter.sv - single-port line-memory arbiter between CPU and host
//
// Purpose: per-cycle arbitration of the line memory between the CPU load/store
//          path and the host preload/debug port, with read-return routing,
//          bounded host starvation and a host exclusive-lock mode.
// Ports:
//   i_clk - clock
//   i_rst - synchronous reset, active-high
//   bus   - linemem_arbiter_if.slave (CPU port, host port, memory port)
// Optional: LMARB_STALL_CNT_EN builds the saturating CPU stall-cycle counter
//           (bus.o_cpu_stall_cnt) with its synchronous clear (bus.i_stall_cnt_clr).
module linemem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  linemem_arbiter_if.slave    bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("linemem_arbiter: DEPTH does not fit in ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_SHARED,
    ST_LOCK_PEND,
    ST_LOCKED
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic                  r_rd_pending;
  logic                  r_rd_host;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_host_rdata;

  logic                  w_cpu_gnt;
  logic                  w_host_gnt;
  logic                  w_granted;
  logic                  w_we;
  logic                  w_mem_re;
  logic                  w_cpu_rvld;
  logic                  w_host_rvld;
  logic                  w_cpu_stall;

  // Grants and next state. Nothing is granted while reset is asserted so no
  // memory strobe can escape during the reset cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_gnt   = 1'b0;
    w_host_gnt  = 1'b0;
    if (!i_rst) begin
      case (r_state)
        ST_SHARED: begin
          // Host wins a collision only once the CPU has used up its run.
          if (bus.i_host_req && (!bus.i_cpu_req || r_starve_cnt == STARVE_LIM)) begin
            w_host_gnt = 1'b1;
          end else if (bus.i_cpu_req) begin
            w_cpu_gnt = 1'b1;
          end
          if (bus.i_host_lock) begin
            w_state_nxt = ST_LOCK_PEND;
          end
        end
        ST_LOCK_PEND: begin
          // No grants here, so any read issued last cycle returns now and
          // nothing is left in flight when the lock is taken.
          w_state_nxt = bus.i_host_lock ? ST_LOCKED : ST_SHARED;
        end
        ST_LOCKED: begin
          w_host_gnt = bus.i_host_req;
          if (!bus.i_host_lock) begin
            w_state_nxt = ST_SHARED;
          end
        end
        default: w_state_nxt = ST_SHARED;
      endcase
    end
  end

  assign w_granted   = w_cpu_gnt | w_host_gnt;
  assign w_we        = w_host_gnt ? bus.i_host_we : bus.i_cpu_we;
  assign w_mem_re    = w_granted & ~w_we;
  assign w_cpu_stall = bus.i_cpu_req & ~w_cpu_gnt;

  // A read issued just before reset must not surface during the reset cycle.
  assign w_cpu_rvld  = r_rd_pending & ~r_rd_host & ~i_rst;
  assign w_host_rvld = r_rd_pending &  r_rd_host & ~i_rst;

  assign bus.o_cpu_gnt     = w_cpu_gnt;
  assign bus.o_host_gnt    = w_host_gnt;
  assign bus.o_cpu_stall   = w_cpu_stall;
  assign bus.o_host_locked = (r_state == ST_LOCKED) & ~i_rst;
  assign bus.o_mem_re      = w_mem_re;
  assign bus.o_mem_we      = w_granted & w_we;
  assign bus.o_mem_addr    = w_host_gnt ? bus.i_host_addr  : bus.i_cpu_addr;
  assign bus.o_mem_wdata   = w_host_gnt ? bus.i_host_wdata : bus.i_cpu_wdata;
  assign bus.o_cpu_rvld    = w_cpu_rvld;
  assign bus.o_host_rvld   = w_host_rvld;
  assign bus.o_cpu_rdata   = w_cpu_rvld  ? bus.i_mem_rdata : r_cpu_rdata;
  assign bus.o_host_rdata  = w_host_rvld ? bus.i_mem_rdata : r_host_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_SHARED;
      r_starve_cnt <= '0;
      r_rd_pending <= 1'b0;
      r_rd_host    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_pending <= w_mem_re;
      if (w_mem_re) begin
        r_rd_host <= w_host_gnt;
      end
      if (w_cpu_rvld) begin
        r_cpu_rdata <= bus.i_mem_rdata;
      end
      if (w_host_rvld) begin
        r_host_rdata <= bus.i_mem_rdata;
      end
      // Counts CPU wins only while the host is actually waiting.
      if (!bus.i_host_req || w_host_gnt) begin
        r_starve_cnt <= '0;
      end else if (w_cpu_gnt && r_starve_cnt != STARVE_LIM) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

`ifdef LMARB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_cpu_stall && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.o_cpu_stall_cnt = r_stall_cnt;
`endif

endmodule
